// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared 32x8 memory.
// The arbiter takes the slave side; requesters and memory sit on the master side.
interface mem_arbiter_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);
  logic              req0, req1, wr0, wr1, lock1;
  logic [AWIDTH-1:0] addr0, addr1, mem_addr;
  logic [DWIDTH-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
  logic              gnt0, gnt1, rvalid0, rvalid1, mem_rd, mem_wr;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, lock1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, lock1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter for the shared program/data memory, with a
// per-owner burst cap and a loader lock on port 1.

module mem_arbiter_rport #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_rd_i,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              rvalid_o,
  output logic [DWIDTH-1:0] rdata_o
);
  logic rvalid_q;

  // Tag captured at access time, so a handover never misroutes the return.
  always_ff @(posedge clk or negedge rst)
    if (!rst) rvalid_q <= 1'b0;
    else      rvalid_q <= acc_rd_i;

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rvalid_q ? mem_rdata_i : '0;
endmodule

module mem_arbiter #(
  parameter int AWIDTH    = 5,
  parameter int DWIDTH    = 8,
  parameter int MAX_BURST = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int NPORT = 2;
  localparam int BW    = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [BW-1:0]   burst_q, burst_d, burst_inc;
  logic            burst_sat, cur, oth;

  logic [NPORT-1:0]             req, wr, gnt, acc, rvalid;
  logic [NPORT-1:0][AWIDTH-1:0] addr;
  logic [NPORT-1:0][DWIDTH-1:0] wdata, rdata;
  logic [AWIDTH-1:0]            mem_addr;
  logic [DWIDTH-1:0]            mem_wdata;
  logic                         mem_rd, mem_wr;

  assign req   = {bus.req1, bus.req0};
  assign wr    = {bus.wr1, bus.wr0};
  assign addr  = {bus.addr1, bus.addr0};
  assign wdata = {bus.wdata1, bus.wdata0};

  function automatic state_e own_st(input logic p);
    return p ? OWN1 : OWN0;
  endfunction

  assign cur       = (state_q == OWN1);
  assign oth       = ~cur;
  assign burst_sat = (burst_q == BURST_LAST);
  assign burst_inc = burst_sat ? burst_q : burst_q + 1'b1;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (&req)        state_d = own_st(~last_q);
        else if (req[0]) state_d = OWN0;
        else if (req[1]) state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (!req[cur])                            state_d = req[oth] ? own_st(oth) : IDLE;
        else if (!req[oth] || (cur && bus.lock1)) burst_d = burst_inc;
        else if (burst_sat)                       state_d = own_st(oth);
        else                                      burst_d = burst_inc;
      end
      default: state_d = IDLE;
    endcase
    // last_q remembers whoever owned most recently, even across IDLE.
    if (state_d != state_q) begin
      burst_d = '0;
      last_d  = (state_d == IDLE) ? cur : (state_d == OWN1);
    end
  end

  always_comb begin
    gnt       = {state_q == OWN1, state_q == OWN0};
    acc       = gnt & req;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    for (int p = 0; p < NPORT; p++)
      if (acc[p]) begin
        mem_addr  = addr[p];
        mem_wdata = wdata[p];
        mem_wr    = wr[p];
        mem_rd    = ~wr[p];
      end
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    mem_arbiter_rport #(.DWIDTH(DWIDTH)) u_rport (
      .clk         (clk),
      .rst         (rst),
      .acc_rd_i    (acc[p] & ~wr[p]),
      .mem_rdata_i (bus.mem_rdata),
      .rvalid_o    (rvalid[p]),
      .rdata_o     (rdata[p])
    );
  end

  assign bus.gnt0      = gnt[0];
  assign bus.gnt1      = gnt[1];
  assign bus.rvalid0   = rvalid[0];
  assign bus.rvalid1   = rvalid[1];
  assign bus.rdata0    = rdata[0];
  assign bus.rdata1    = rdata[1];
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_wr    = mem_wr;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against an ownership/queue model of the arbiter.
module tb_mem_arbiter;
  localparam int AW = 5, DW = 8, MB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus();
  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  // Memory device: write commits at the edge, read data one cycle after mem_rd.
  logic [DW-1:0] mem_dev [32];
  always @(posedge clk) begin
    if (bus.mem_wr) mem_dev[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= mem_dev[bus.mem_addr];
  end

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns, how long they have held it, who went last, shadow memory.
  int            m_own = -1, m_last = 1, m_held = 0;
  logic [DW-1:0] shadow [32];
  bit            m_rv [2];
  logic [DW-1:0] m_rd [2];

  task automatic model_step();
    bit            rq [2];
    bit            w  [2];
    logic [AW-1:0] a  [2];
    logic [DW-1:0] d  [2];
    int            nxt;
    rq = '{bus.req0, bus.req1};   w = '{bus.wr0, bus.wr1};
    a  = '{bus.addr0, bus.addr1}; d = '{bus.wdata0, bus.wdata1};
    m_rv = '{0, 0};
    if (m_own >= 0 && rq[m_own]) begin
      if (w[m_own]) shadow[a[m_own]] = d[m_own];
      else begin m_rv[m_own] = 1; m_rd[m_own] = shadow[a[m_own]]; end
    end
    nxt = m_own;
    if (m_own < 0) begin
      if (rq[0] && rq[1]) nxt = 1 - m_last;
      else if (rq[0])     nxt = 0;
      else if (rq[1])     nxt = 1;
    end else if (!rq[m_own]) begin
      nxt = rq[1-m_own] ? 1 - m_own : -1;
    end else if (rq[1-m_own] && !(m_own == 1 && bus.lock1) && m_held >= MB) begin
      nxt = 1 - m_own;
    end
    if (nxt != m_own) begin
      m_last = (nxt >= 0) ? nxt : m_own;
      m_held = (nxt >= 0) ? 1 : 0;
      m_own  = nxt;
    end else if (m_own >= 0) m_held++;
  endtask

  // Compare process: outputs at the falling edge, model advance at the rising edge.
  always begin
    @(negedge clk);
    if (!rst_n) begin
      chk("reset_outs", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_rd, bus.mem_wr,
                         bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1}, 64'd0);
      m_own = -1; m_last = 1; m_held = 0; m_rv = '{0, 0};
    end else begin
      logic [14:0] exp_bus;
      exp_bus = '0;
      if (m_own == 0 && bus.req0) exp_bus = {~bus.wr0, bus.wr0, bus.addr0, bus.wdata0};
      if (m_own == 1 && bus.req1) exp_bus = {~bus.wr1, bus.wr1, bus.addr1, bus.wdata1};
      chk("gnt", {bus.gnt1, bus.gnt0}, {m_own == 1, m_own == 0});
      chk("mem_bus", {bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata}, exp_bus);
      chk("rvalid", {bus.rvalid1, bus.rvalid0}, {m_rv[1], m_rv[0]});
      chk("rdata0", bus.rdata0, m_rv[0] ? m_rd[0] : '0);
      chk("rdata1", bus.rdata1, m_rv[1] ? m_rd[1] : '0);
    end
    @(posedge clk);
    if (rst_n) model_step();
  end

  task automatic set_p0(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req0 = r; bus.wr0 = w; bus.addr0 = a; bus.wdata0 = d;
  endtask
  task automatic set_p1(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit l);
    bus.req1 = r; bus.wr1 = w; bus.addr1 = a; bus.wdata1 = d; bus.lock1 = l;
  endtask
  task automatic tick();
    @(posedge clk); #2;
  endtask

  initial begin
    logic [DW-1:0] v;
    set_p0(0, 0, 0, 0); set_p1(0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      v = DW'($urandom);
      mem_dev[i] <= v; shadow[i] = v;
    end
    mem_dev[5] <= 8'hA3; shadow[5] = 8'hA3;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    chk("reset_gnt", {bus.gnt1, bus.gnt0, bus.mem_rd}, 0);
    rst_n = 1'b1;

    // Read of addr 5 from IDLE: grant + access next cycle, data the cycle after.
    set_p0(1, 0, 5, 0);
    tick(); #1;
    chk("a_gnt0", bus.gnt0, 1); chk("a_mem_rd", bus.mem_rd, 1); chk("a_addr", bus.mem_addr, 5);
    tick(); set_p0(0, 0, 0, 0); #1;
    chk("a_rvalid0", bus.rvalid0, 1); chk("a_rdata0", bus.rdata0, 8'hA3); chk("a_rvalid1", bus.rvalid1, 0);

    // Port 1 writes 5C to 31, reads it back next cycle; port 0 reads it after handover.
    tick(); set_p1(1, 1, 31, 8'h5C, 0);
    tick(); #1;
    chk("b_wr", {bus.gnt1, bus.mem_wr, bus.mem_addr, bus.mem_wdata}, {1'b1, 1'b1, 5'd31, 8'h5C});
    tick(); set_p1(1, 0, 31, 0, 0); set_p0(1, 0, 31, 0); #1;
    chk("b_rd1", {bus.gnt1, bus.mem_rd}, 2'b11);
    tick(); set_p1(0, 0, 0, 0, 0); #1;
    chk("b_rdata1", {bus.rvalid1, bus.rdata1}, {1'b1, 8'h5C});
    tick(); #1; chk("b_gnt0", bus.gnt0, 1);
    tick(); set_p0(0, 0, 0, 0); #1;
    chk("b_rdata0", {bus.rvalid0, bus.rdata0}, {1'b1, 8'h5C});

    // Lock: port 1 holds through 10+ contended cycles, port 0 follows one cycle after release.
    tick(); set_p0(1, 0, 1, 0); set_p1(1, 0, 2, 0, 1);
    for (int k = 0; k < 10; k++) begin tick(); #1; chk("c_lock_gnt1", bus.gnt1, 1); end
    tick(); bus.lock1 = 0; #1; chk("c_last_gnt1", bus.gnt1, 1);
    tick(); #1; chk("c_gnt0_after", bus.gnt0, 1);
    tick(); set_p0(0, 0, 0, 0); set_p1(0, 0, 0, 0, 0);
    tick();

    // Port 0 read in its last owned cycle before switching to port 1.
    set_p0(1, 0, 5, 0);
    tick(); set_p1(1, 0, 3, 0, 0);
    repeat (3) tick();
    #1; chk("d_last_gnt0", bus.gnt0, 1);
    tick(); #1;
    chk("d_switch", {bus.gnt1, bus.rvalid0, bus.rdata0, bus.rvalid1}, {1'b1, 1'b1, 8'hA3, 1'b0});
    set_p0(0, 0, 0, 0); set_p1(0, 0, 0, 0, 0);
    repeat (3) tick();

    // Reset right after a port 0 read access: the read never returns.
    set_p0(1, 0, 9, 0);
    tick(); #1; chk("e_gnt0", {bus.gnt0, bus.mem_rd}, 2'b11);
    tick(); rst_n = 1'b0; #1;
    chk("e_reset_outs", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_rd, bus.mem_wr,
                         bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1}, 64'd0);
    tick(); set_p1(1, 0, 4, 0, 0); #1; chk("e_rvalid0_rst", bus.rvalid0, 0);
    tick(); rst_n = 1'b1; #1; chk("e_rvalid0_rel", bus.rvalid0, 0);
    // Tie after reset goes to port 0, then 4/4 alternation with no dead cycle.
    for (int i = 0; i < 16; i++) begin
      tick(); #1;
      chk("e_burst_pattern", {bus.gnt1, bus.gnt0}, ((i / MB) % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Random traffic with occasional lock and reset pulses.
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst_n = ($urandom_range(0, 499) != 0);
      set_p0($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, AW'($urandom), DW'($urandom));
      set_p1($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, AW'($urandom), DW'($urandom),
             $urandom_range(0, 9) < 2);
    end
    tick(); rst_n = 1'b1;
    set_p0(0, 0, 0, 0); set_p1(0, 0, 0, 0, 0);
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the VeriRISC single-port 32×8 program/data memory between the CPU core (port 0) and a loader/debug host (port 1). It owns the memory address, control and write-data lines and returns read data to the requester that issued the read. A three-state ownership FSM provides round-robin fairness and a per-owner burst cap; the loader can lock ownership while it downloads a program image.

## Interface
- AWIDTH, 5, memory address width
- DWIDTH, 8, memory data width
- MAX_BURST, 4, maximum consecutive owned cycles while the other port waits (≥1)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req0 / req1  in  1  port requests an access this cycle
- wr0 / wr1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AWIDTH  access address
- wdata0 / wdata1  in  DWIDTH  write data
- lock1  in  1  loader holds ownership (port 1 only)
- gnt0 / gnt1  out  1  port currently owns memory
- rvalid0 / rvalid1  out  1  read data valid for that port
- rdata0 / rdata1  out  DWIDTH  read data; 0 when the matching rvalid is low
- mem_addr  out  AWIDTH  to memory
- mem_rd / mem_wr  out  1  memory read/write strobes
- mem_wdata  out  DWIDTH  to memory
- mem_rdata  in  DWIDTH  memory read data, valid the cycle after mem_rd

## Operation
- States: IDLE, OWN0, OWN1. gnt0 = (state==OWN0), gnt1 = (state==OWN1), decoded from state only.
- Access in a cycle: acc_x = gnt_x & req_x. During acc_x: mem_addr = addr_x, mem_wdata = wdata_x, mem_wr = wr_x, mem_rd = ~wr_x. With no access, all mem_* outputs are 0.
- last_owner register (reset 1) breaks ties. burst_cnt (width clog2(MAX_BURST)+1, reset 0) counts consecutive owned cycles.
- IDLE: req0 & req1 → own the port ≠ last_owner. One request → own that port. None → stay IDLE.
- OWNx, req_x low: other port requesting → OWN(other), else IDLE.
- OWNx, req_x high, other port idle → stay; burst_cnt saturates at MAX_BURST-1.
- OWNx, req_x high, other port requesting:
  - x==1 & lock1 → stay; burst limit not applied.
  - else burst_cnt == MAX_BURST-1 → switch to OWN(other).
  - else stay, burst_cnt+1.
- On every ownership change (including to/from IDLE): burst_cnt ← 0, last_owner ← new/old owner.
- lock1 is ignored unless the state is OWN1.
- Read return: rvalid_x ← acc_x & ~wr_x (registered). rdata_x = rvalid_x ? mem_rdata : 0. The return tag is captured at access time, so ownership switches never misroute data.
- Write: committed by the memory at the edge ending the access cycle. A read of the same address in the next cycle returns the new data.

## Timing
- Reset (rst low, asynchronous): state IDLE; gnt*, rvalid*, rdata*, all mem_* = 0; last_owner=1; burst_cnt=0. An in-flight read is discarded, with no rvalid after release.
- Request latency from IDLE: req at cycle n → gnt at n+1, first access at n+1.
- While owned: one access per cycle, zero bubbles.
- Handover with both requesting: last owner access at cycle n, new owner gnt and access at n+1; no dead cycle.
- Read latency: access at n → rvalid/rdata at n+1.
- Fairness: unlocked, each port waits ≤ MAX_BURST cycles once requesting against a busy owner.
- Simultaneous first request from IDLE after reset → port 0 wins.

## Test plan
- Reset then req0 read addr 5 (mem[5]=8'hA3), req1 low → gnt0 at cycle 1, mem_rd=1, mem_addr=5; rvalid0=1, rdata0=8'hA3 at cycle 2; rvalid1=0.
- req0 and req1 both held high from IDLE, MAX_BURST=4, no lock → gnt0 for 4 cycles, gnt1 for 4 cycles, repeating; no cycle without a grant.
- Port 1 writes 8'h5C to addr 31, then port 0 reads addr 31 on the next cycle → rdata0=8'h5C.
- lock1=1, req1 held for 10 cycles while req0 is high → gnt1 for all 10 cycles; gnt0 one cycle after lock1 or req1 drops.
- Port 0 read issued in the last owned cycle before a switch to port 1 → rvalid0 pulses the next cycle with correct data; rvalid1 stays 0.
- rst asserted the cycle after a port 0 read access → rvalid0 never asserts; all outputs 0 during reset; first post-release tie grants port 0.
